// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for mem_arbiter: FSM states, requester ids and
// the block-base helper used when a fill is granted.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;
  typedef enum logic {REQ_I, REQ_D} req_id_e;

  localparam int MEM_LAT_DEF   = 4;
  localparam int BLK_WORDS_DEF = 8;

  // Byte address of the first word of the block holding addr (16-bit words).
  function automatic logic [15:0] blk_base(input logic [15:0] addr, input int offw);
    logic [15:0] mask;
    mask = 16'hFFFF << (offw + 1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and fill-return signals of mem_arbiter. The arbiter uses
// the master modport; requesters and the memory model sit on the slave side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int BLK_WORDS = BLK_WORDS_DEF
);
  localparam int OFFW = $clog2(BLK_WORDS);

  logic            i_req;
  logic [15:0]     i_addr;
  logic            d_req;
  logic            d_wr;
  logic [15:0]     d_addr;
  logic [15:0]     d_wdata;
  logic [15:0]     mem_addr;
  logic            mem_en;
  logic            mem_wr;
  logic [15:0]     mem_wdata;
  logic [15:0]     mem_rdata;
  logic            mem_rvalid;
  logic [15:0]     fill_data;
  logic [OFFW-1:0] fill_offset;
  logic            i_fill_we;
  logic            d_fill_we;
  logic            i_done;
  logic            d_done;
  logic            busy;

  modport master (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output mem_addr, mem_en, mem_wr, mem_wdata, fill_data, fill_offset,
           i_fill_we, d_fill_we, i_done, d_done, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  mem_addr, mem_en, mem_wr, mem_wdata, fill_data, fill_offset,
           i_fill_we, d_fill_we, i_done, d_done, busy
  );

endinterface

// File: rtl/mem_arbiter_blk_counter.sv
// blk_counter: W-bit word counter with synchronous clear, enable and an
// all-ones terminal-count flag; used for both issue and return indices.
module blk_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = &cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-side block fills and D-side fills/write-throughs onto
// one multi-cycle memory. Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT   = MEM_LAT_DEF,
  parameter int BLK_WORDS = BLK_WORDS_DEF
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  localparam int OFFW = $clog2(BLK_WORDS);

  if (MEM_LAT < 1 || BLK_WORDS < 2 || (1 << OFFW) != BLK_WORDS) begin : g_bad_param
    $error("mem_arbiter: MEM_LAT must be >= 1 and BLK_WORDS a power of two >= 2");
  end

  state_e          state_q, state_d;
  req_id_e         owner_q, owner_d, grant;
  logic [15:0]     base_q, base_d;
  logic [15:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic            mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic            any_req, grant_wr;
  logic [OFFW-1:0] icnt, rcnt, icnt_nxt;
  logic            icnt_tc, rcnt_tc, icnt_en, rcnt_en, cnt_clr;
  logic [15:0]     ofs_nxt;
  logic            fill_rv, fill_done;
  logic [15:0]     fill_data;
  logic            i_fill_we, d_fill_we, i_done, d_done;

  assign any_req  = bus.i_req | bus.d_req;
  assign grant_wr = (grant == REQ_D) && bus.d_wr;

`ifdef MEM_ARB_RR_EN
  req_id_e last_grant_q, last_grant_d;

  // On a tie the side that did not win last time goes first.
  always_comb begin
    grant = bus.d_req ? REQ_D : REQ_I;
    if (bus.i_req && bus.d_req) grant = (last_grant_q == REQ_D) ? REQ_I : REQ_D;
    last_grant_d = last_grant_q;
    if (state_q == IDLE && any_req) last_grant_d = grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= REQ_D;
    else     last_grant_q <= last_grant_d;
  end
`else
  always_comb grant = bus.d_req ? REQ_D : REQ_I;
`endif

  blk_counter #(.W(OFFW)) u_icnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(icnt_en), .cnt(icnt), .tc(icnt_tc)
  );

  blk_counter #(.W(OFFW)) u_rcnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(rcnt_en), .cnt(rcnt), .tc(rcnt_tc)
  );

  assign cnt_clr  = (state_q != FILL);
  assign icnt_en  = (state_q == FILL) && mem_en_q && !icnt_tc;
  assign rcnt_en  = fill_rv;
  assign icnt_nxt = icnt + 1'b1;
  assign ofs_nxt  = 16'({icnt_nxt, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= REQ_I;
      base_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = grant_wr ? WRITE : FILL;
      FILL:    if (fill_done) state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    base_d      = base_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: if (any_req) begin
        owner_d  = grant;
        mem_en_d = 1'b1;
        if (grant_wr) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end else begin
          base_d     = blk_base((grant == REQ_D) ? bus.d_addr : bus.i_addr, OFFW);
          mem_addr_d = base_d;
        end
      end
      // Reads are issued one per cycle; the register holds the next word's address.
      FILL: if (mem_en_q && !icnt_tc) begin
        mem_en_d   = 1'b1;
        mem_addr_d = base_q + ofs_nxt;
      end
      default: ;
    endcase

    fill_rv   = (state_q == FILL) && bus.mem_rvalid;
    fill_done = fill_rv && rcnt_tc;
    fill_data = fill_rv ? bus.mem_rdata : 16'h0000;
    i_fill_we = fill_rv && (owner_q == REQ_I);
    d_fill_we = fill_rv && (owner_q == REQ_D);
    i_done    = fill_done && (owner_q == REQ_I);
    d_done    = (fill_done && (owner_q == REQ_D)) || (state_q == WRITE);
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.fill_data   = fill_data;
  assign bus.fill_offset = rcnt;
  assign bus.i_fill_we   = i_fill_we;
  assign bus.d_fill_we   = d_fill_we;
  assign bus.i_done      = i_done;
  assign bus.d_done      = d_done;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a latency-accurate memory model,
// a transaction-level reference predicting every issue, write and fill word.
module tb_mem_arbiter;

  localparam int LAT = 4;
  localparam int BLK = 8;

  typedef struct { logic [15:0] addr; int cyc; } iss_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; int cyc; } wr_t;
  typedef struct { bit side_d; logic [2:0] ofs; logic [15:0] data; int cyc; bit done; } fill_t;
  typedef struct { int due; logic [15:0] data; } pend_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   free_cyc;
  bit   rr_last;

  iss_t  iq[$];
  wr_t   wq[$];
  fill_t fq[$];
  pend_t pend[$];
  logic [15:0] shadow  [int];
  logic [15:0] ref_mem [int];

  mem_arbiter_if #(.BLK_WORDS(BLK)) bus ();

  mem_arbiter #(.MEM_LAT(LAT), .BLK_WORDS(BLK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, nothing expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [63:0] all_outputs();
    return {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_data,
            bus.fill_offset, bus.i_fill_we, bus.d_fill_we, bus.i_done, bus.d_done, bus.busy};
  endfunction

  // Reference: a granted transaction starts once both its request is up and the
  // arbiter is free; fills take BLK issues then MEM_LAT, writes take one cycle.
  task automatic predict(input bit side_d, input bit wr, input logic [15:0] addr,
                         input logic [15:0] data, input int t);
    int g;
    logic [15:0] base, a;
    g = (t > free_cyc) ? t : free_cyc;
    rr_last = side_d;
    if (wr) begin
      wq.push_back('{addr: addr, data: data, cyc: g + 1});
      ref_mem[int'(addr)] = data;
      free_cyc = g + 2;
    end else begin
      base = addr & ~16'(2 * BLK - 1);
      for (int k = 0; k < BLK; k++) begin
        a = base + 16'(2 * k);
        iq.push_back('{addr: a, cyc: g + 1 + k});
        fq.push_back('{side_d: side_d, ofs: 3'(k), data: ref_rd(a), cyc: g + 1 + k + LAT,
                       done: (k == BLK - 1)});
      end
      free_cyc = g + BLK + LAT + 1;
    end
  endtask

  task automatic request(input bit side_d, input bit wr, input logic [15:0] addr,
                         input logic [15:0] data);
    if (side_d) begin
      bus.d_req = 1'b1; bus.d_wr = wr; bus.d_addr = addr; bus.d_wdata = data;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    for (int n = 0; n < 200; n++) begin
      if (side_d ? bus.d_done : bus.i_done) begin
        if (side_d) bus.d_req = 1'b0;
        else        bus.i_req = 1'b0;
        return;
      end
      @(negedge clk);
    end
    note_fail(side_d ? "d_done_timeout" : "i_done_timeout", {48'b0, addr});
    if (side_d) bus.d_req = 1'b0;
    else        bus.i_req = 1'b0;
  endtask

  task automatic single(input bit side_d, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data);
    predict(side_d, wr, addr, data, cyc);
    request(side_d, wr, addr, data);
  endtask

  task automatic tie(input logic [15:0] i_addr, input bit d_wr, input logic [15:0] d_addr,
                     input logic [15:0] d_data);
    bit d_first;
`ifdef MEM_ARB_RR_EN
    d_first = !rr_last;
`else
    d_first = 1'b1;
`endif
    if (d_first) begin
      predict(1'b1, d_wr, d_addr, d_data, cyc);
      predict(1'b0, 1'b0, i_addr, 16'h0, cyc);
    end else begin
      predict(1'b0, 1'b0, i_addr, 16'h0, cyc);
      predict(1'b1, d_wr, d_addr, d_data, cyc);
    end
    fork
      request(1'b0, 1'b0, i_addr, 16'h0);
      request(1'b1, d_wr, d_addr, d_data);
    join
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(2))
      0:       return 16'hFFF0 | 16'($urandom_range(15));
      1:       return 16'h0200 | 16'($urandom_range(31));
      default: return r;
    endcase
  endfunction

  // Memory model: reads return MEM_LAT cycles after issue; also owns the cycle count.
  initial begin
    bit spur;
    cyc = 0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_wr) shadow[int'(bus.mem_addr)] = bus.mem_wdata;
        else pend.push_back('{due: cyc + LAT,
                              data: shadow.exists(int'(bus.mem_addr)) ?
                                    shadow[int'(bus.mem_addr)] : init_val(bus.mem_addr)});
      end
      spur = !bus.busy && !bus.i_req && !bus.d_req && ($urandom_range(7) == 0);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = pend[0].data;
        void'(pend.pop_front());
      end else begin
        bus.mem_rvalid = spur;
        bus.mem_rdata  = 16'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues, writes or returns a word.
  initial begin
    iss_t  ie;
    wr_t   we;
    fill_t fe;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_wr) check("mem_wr_needs_en", bus.mem_en, 1);
        if (bus.mem_en && bus.mem_wr) begin
          if (wq.size() == 0) note_fail("unexpected_write", bus.mem_addr);
          else begin
            we = wq.pop_front();
            check("wr_addr", bus.mem_addr, we.addr);
            check("wr_data", bus.mem_wdata, we.data);
            check("wr_cycle", cyc, we.cyc);
            check("wr_done_pair", {bus.i_done, bus.d_done}, 2'b01);
          end
        end else if (bus.mem_en) begin
          if (iq.size() == 0) note_fail("unexpected_issue", bus.mem_addr);
          else begin
            ie = iq.pop_front();
            check("issue_addr", bus.mem_addr, ie.addr);
            check("issue_cycle", cyc, ie.cyc);
          end
        end
        if (bus.i_fill_we || bus.d_fill_we) begin
          if (fq.size() == 0) note_fail("unexpected_fill_we", {bus.i_fill_we, bus.d_fill_we});
          else begin
            fe = fq.pop_front();
            check("fill_we_pair", {bus.i_fill_we, bus.d_fill_we}, fe.side_d ? 2'b01 : 2'b10);
            check("fill_offset", bus.fill_offset, fe.ofs);
            check("fill_data", bus.fill_data, fe.data);
            check("fill_cycle", cyc, fe.cyc);
            check("fill_done_pair", {bus.i_done, bus.d_done},
                  fe.done ? (fe.side_d ? 2'b01 : 2'b10) : 2'b00);
          end
        end else if (!(bus.mem_en && bus.mem_wr) && (bus.i_done || bus.d_done)) begin
          note_fail("unexpected_done", {bus.i_done, bus.d_done});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, w;
    n_checks = 0; n_fail = 0; free_cyc = 0; rr_last = 1'b1;
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 16'h0; bus.d_req = 1'b0; bus.d_wr = 1'b0;
    bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);

    // I fill from an unaligned address: issues 0x1230..0x123E, i_done at T+12.
    @(negedge clk);
    single(1'b0, 1'b0, 16'h1236, 16'h0);
    @(negedge clk);
    check("busy_after_ifill", bus.busy, 0);

    // Single D write: write and d_done at T+1, idle at T+2.
    single(1'b1, 1'b1, 16'h00A0, 16'hBEEF);
    @(negedge clk);
    check("busy_after_dwrite", bus.busy, 0);

    // Repeated I/D fill ties.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tie(16'h3000 + 16'(k * 16), 1'b0, 16'h0200 + 16'(k * 16), 16'h0);
    end

    // D writes with d_req held and the address changing at each d_done.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 16'h0204 + 16'(k * 2);
      w = 16'($urandom);
      bus.d_addr = a; bus.d_wdata = w;
      predict(1'b1, 1'b1, a, w, cyc);
      for (int n = 0; n < 10 && !bus.d_done; n++) @(negedge clk);
      if (!bus.d_done) note_fail("b2b_write_timeout", {48'b0, a});
      if (k < 3) begin
        @(negedge clk);
        check("b2b_gap_no_done", bus.d_done, 0);
        // The gap cycle is IDLE; the next write lands one cycle later.
        a = 16'h0204 + 16'((k + 1) * 2);
      end
    end
    bus.d_req = 1'b0;

    // Reset asserted at the third returned word of an I fill.
    @(negedge clk);
    @(negedge clk);
    predict(1'b0, 1'b0, 16'h4A10, 16'h0, cyc);
    bus.i_req = 1'b1; bus.i_addr = 16'h4A10;
    repeat (7) @(posedge clk);
    #2;
    check("pre_reset_fill_we", bus.i_fill_we, 1);
    check("pre_reset_offset", bus.fill_offset, 2);
    rst = 1'b1;
    #1;
    check("reset_mid_fill_outputs", all_outputs(), 64'h0);
    iq.delete(); fq.delete(); free_cyc = 0; rr_last = 1'b1;
    bus.i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("late_rvalid_ignored", {bus.i_fill_we, bus.d_fill_we, bus.busy}, 3'b000);
    end
    single(1'b0, 1'b0, 16'h4A10, 16'h0);

    // Randomised mix of fills, writes and ties.
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      @(negedge clk);
      case ($urandom_range(3))
        0:       single(1'b0, 1'b0, rand_addr(), 16'h0);
        1:       single(1'b1, 1'b0, rand_addr(), 16'h0);
        2:       single(1'b1, 1'b1, rand_addr() & 16'hFFFE, 16'($urandom));
        default: tie(rand_addr(), 1'($urandom_range(1)), rand_addr() & 16'hFFFE, 16'($urandom));
      endcase
    end

    repeat (20) @(negedge clk);
    check("issue_queue_drained", iq.size(), 0);
    check("write_queue_drained", wq.size(), 0);
    check("fill_queue_drained", fq.size(), 0);
    check("final_busy", bus.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the single multi-cycle main memory between the instruction-side and data-side cache controllers of the pipelined CPU. It performs block fills of BLK_WORDS words and single-word write-throughs. Each transaction is serialized behind a one-hot grant. The block sits between the two cache FSMs and the `memory4c`-style main memory. Issue and return counters track outstanding reads.

## Interface

Parameters:
- MEM_LAT, 4: cycles from a `mem_en` read issue to the matching `mem_rvalid`.
- BLK_WORDS, 8: words per cache block. Power of two; offset width OFFW = log2(BLK_WORDS).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- i_req, input, 1: I-side fill request. Level; held until `i_done`.
- i_addr, input, 16: I-side miss byte address. Block base = addr with low OFFW+1 bits cleared.
- d_req, input, 1: D-side request. Level; held until `d_done`.
- d_wr, input, 1: 1 = single-word write, 0 = block fill.
- d_addr, input, 16: D-side byte address.
- d_wdata, input, 16: D-side write data.
- mem_addr, output, 16: memory byte address.
- mem_en, output, 1: memory access strobe.
- mem_wr, output, 1: memory write enable. Only ever set together with `mem_en`.
- mem_wdata, output, 16: memory write data.
- mem_rdata, input, 16: memory read data.
- mem_rvalid, input, 1: read data valid.
- fill_data, output, 16: returned word, broadcast to both sides.
- fill_offset, output, OFFW: word index of `fill_data`.
- i_fill_we, output, 1: write `fill_data` into the I-cache.
- d_fill_we, output, 1: write `fill_data` into the D-cache.
- i_done, output, 1: one-cycle pulse, I transaction complete.
- d_done, output, 1: one-cycle pulse, D transaction complete.
- busy, output, 1: state is not IDLE.

## Operation

- States:
  - IDLE
  - FILL: tracks owner I or D.
  - WRITE
- IDLE behaviour:
  - Samples `i_req` and `d_req`.
  - No request: stay in IDLE.
  - `d_req & d_wr`: go to WRITE.
  - Otherwise the granted requester goes to FILL.
  - Requester addresses are latched at grant.
- FILL behaviour:
  - Issue counter `icnt` 0..BLK_WORDS-1 drives one read per cycle, `mem_addr = base + 2*icnt`.
  - `mem_en` drops after the last issue.
  - Return counter `rcnt` increments on each `mem_rvalid`.
  - `fill_offset = rcnt`, `fill_data = mem_rdata`.
  - The owner's `fill_we` equals `mem_rvalid`; the other side's `fill_we` is 0.
  - Owner's `done` is asserted combinationally with the BLK_WORDS-th `mem_rvalid`, then the FSM goes to IDLE.
- WRITE behaviour:
  - One cycle with `mem_en = mem_wr = 1`, `mem_addr = d_addr`, `mem_wdata = d_wdata`.
  - `d_done` in that same cycle, then IDLE.
- Arbitration on a tie is fixed priority, D over I, unless the macro in Configuration is defined.
- `mem_rvalid` in IDLE or WRITE is ignored: no `fill_we` and no counter change.
- Requesters must deassert `req` in the cycle `done` is seen. The FSM is in IDLE on the next cycle and may grant immediately.
- Address wrap: `base + 2*icnt` is computed mod 2^16. Block alignment means it never crosses a block.

## Timing

- Reset values: all outputs 0, state IDLE, counters 0. Reset applies asynchronously at any point, including mid-fill. In-flight returns after reset are discarded because the state is IDLE.
- Request high in IDLE at cycle T:
  - FILL: issues occupy T+1..T+BLK_WORDS. Returns arrive T+1+MEM_LAT..T+BLK_WORDS+MEM_LAT. `done` occurs at T+BLK_WORDS+MEM_LAT, which is T+12 with the defaults.
  - WRITE: the write and `d_done` occur at T+1.
- Back-to-back: the next grant is decided in the cycle after `done`.
- `mem_*` outputs are registered. `fill_*` and `done` outputs are combinational from `mem_rvalid` and registered state.

## Configuration

- MEM_ARB_RR_EN undefined: fixed priority, D wins every tie.
- MEM_ARB_RR_EN defined: a `last_grant` register (reset = D) is added. On a tie, the grant goes to the requester not granted last, so I wins the first tie after reset. Non-tie behaviour is identical to the undefined case.

## Structure

- Package `mem_arb_pkg`:
  - state enum {IDLE, FILL, WRITE}
  - requester id enum {REQ_I, REQ_D}
  - default MEM_LAT and BLK_WORDS constants
- Sub-module `blk_counter`: OFFW-bit counter with clear, enable and terminal-count flag. Instantiated twice, once for issue and once for return.

## Test plan

- Reset mid-fill: assert `rst` at the 3rd return. All outputs go to 0 immediately. Late `mem_rvalid` pulses produce no `fill_we`. The next request starts with offset 0.
- I fill, `i_addr = 0x1236`, default parameters:
  - `mem_addr` sequence is 0x1230..0x123E across T+1..T+8.
  - `i_fill_we` occurs at T+5..T+12 with offsets 0..7.
  - `i_done` occurs at T+12.
  - `d_fill_we` stays 0 throughout.
- D write, `d_addr = 0x00A0`, `d_wdata = 0xBEEF`: at T+1, `mem_en = mem_wr = 1`, `mem_addr = 0x00A0`, `mem_wdata = 0xBEEF`, and `d_done = 1`. `busy` = 0 at T+2.
- Simultaneous `i_req` and D fill request:
  - Without MEM_ARB_RR_EN: D fill first, then I fill granted the cycle after `d_done`.
  - With MEM_ARB_RR_EN: I first after reset, then alternating over repeated ties.
- Back-to-back D writes with `d_req` held and the address changing: one write every 2 cycles, each with exactly one `d_done`.
